// File: rtl/mem_ctrl_burst_if.sv
// Bus bundle for mem_ctrl_burst: RAM byte port, fetcher line-fill port and LSU port.
// The controller uses the slave view; the surrounding system (or a bench) uses master.
interface mem_ctrl_burst_if #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4
);
  logic                     ram_wr_o;
  logic [ADDR_W-1:0]        ram_addr_o;
  logic [7:0]               ram_wdata_o;
  logic [7:0]               ram_rdata_i;

  logic                     if_req_i;
  logic [ADDR_W-1:0]        if_addr_i;
  logic                     if_flush_i;
  logic                     if_done_o;
  logic [32*LINE_WORDS-1:0] if_data_o;

  logic                     ls_req_i;
  logic                     ls_we_i;
  logic [1:0]               ls_size_i;
  logic [ADDR_W-1:0]        ls_addr_i;
  logic [31:0]              ls_wdata_i;
  logic                     ls_done_o;
  logic [31:0]              ls_rdata_o;

  modport slave (
    output ram_wr_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i,
    input  if_req_i, if_addr_i, if_flush_i,
    output if_done_o, if_data_o,
    input  ls_req_i, ls_we_i, ls_size_i, ls_addr_i, ls_wdata_i,
    output ls_done_o, ls_rdata_o
  );

  modport master (
    input  ram_wr_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i,
    output if_req_i, if_addr_i, if_flush_i,
    input  if_done_o, if_data_o,
    output ls_req_i, ls_we_i, ls_size_i, ls_addr_i, ls_wdata_i,
    input  ls_done_o, ls_rdata_o
  );
endinterface

// File: rtl/mem_ctrl_burst.sv
// Byte-serial RAM controller sharing one 8-bit RAM port between icache line fills and LSU accesses.
// Define MEMCTRL_RR_ARB_EN for round-robin arbitration; otherwise the LSU always wins ties.
module mem_ctrl_burst #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  mem_ctrl_burst_if.slave   bus
);
  localparam int NB = 4 * LINE_WORDS;
  localparam int CW = $clog2(NB + 1);

  typedef enum logic [2:0] {IDLE, LS_RD, LS_WR, IF_RD, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next, n_reg, idx, ls_n;
  logic [ADDR_W-1:0] base_reg;
  logic              is_if_reg, we_reg;
  logic [31:0]       wdata_reg, wdata_sh;
  logic [31:0]       ld_buf_reg, ld_next, ld_mask, ls_rdata_reg;
  logic [8*NB-1:0]   line_buf_reg, line_next, if_data_reg;
  logic              fetch_req, can_grant, ls_wins, grant_ls, grant_if;
  logic              done_go, if_done_w, ls_done_w, cap_if, cap_ls;

  assign fetch_req = bus.if_req_i & ~bus.if_flush_i;
  // Reset is folded in so the combinational grant path cannot drive the RAM while held in reset.
  assign can_grant = (state_reg == IDLE) & rdy_in & rst_n_in;

`ifdef MEMCTRL_RR_ARB_EN
  logic fetch_last_reg;
  assign ls_wins = bus.ls_req_i & (~fetch_req | fetch_last_reg);
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)     fetch_last_reg <= 1'b1;
    else if (grant_ls) fetch_last_reg <= 1'b0;
    else if (grant_if) fetch_last_reg <= 1'b1;
  end
`else
  assign ls_wins = bus.ls_req_i;
`endif

  assign grant_ls = can_grant & ls_wins;
  assign grant_if = can_grant & fetch_req & ~ls_wins;

  always_comb begin
    ls_n = CW'(4);
    case (bus.ls_size_i)
      2'd0:    ls_n = CW'(1);
      2'd1:    ls_n = CW'(2);
      default: ls_n = CW'(4);
    endcase
  end

  // Reads keep the last byte's address on the bus during the trailing capture cycle.
  assign idx      = (cnt_reg >= n_reg) ? n_reg - CW'(1) : cnt_reg;
  assign wdata_sh = wdata_reg >> (8 * cnt_reg);

  assign cap_if = (state_reg == IF_RD) & rdy_in;
  assign cap_ls = (state_reg == LS_RD) & rdy_in;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_line
      assign line_next[8*gi +: 8] = (cap_if && cnt_reg == CW'(gi + 1)) ? bus.ram_rdata_i
                                                                        : line_buf_reg[8*gi +: 8];
    end
    for (gi = 0; gi < 4; gi++) begin : g_ld
      assign ld_next[8*gi +: 8] = (cap_ls && cnt_reg == CW'(gi + 1)) ? bus.ram_rdata_i
                                                                      : ld_buf_reg[8*gi +: 8];
      assign ld_mask[8*gi +: 8] = (n_reg > CW'(gi)) ? 8'hFF : 8'h00;
    end
  endgenerate

  assign done_go   = (state_reg == DONE) & rdy_in;
  assign if_done_w = done_go & is_if_reg & ~bus.if_flush_i;
  assign ls_done_w = done_go & ~is_if_reg;

  assign bus.if_done_o  = if_done_w;
  assign bus.ls_done_o  = ls_done_w;
  assign bus.if_data_o  = if_done_w ? line_buf_reg : if_data_reg;
  assign bus.ls_rdata_o = (ls_done_w & ~we_reg) ? (ld_buf_reg & ld_mask) : ls_rdata_reg;

  assign bus.ram_addr_o  = grant_ls ? bus.ls_addr_i :
                           grant_if ? bus.if_addr_i : base_reg + ADDR_W'(idx);
  assign bus.ram_wr_o    = rdy_in & ((grant_ls & bus.ls_we_i) | (state_reg == LS_WR));
  assign bus.ram_wdata_o = (grant_ls & bus.ls_we_i) ? bus.ls_wdata_i[7:0] :
                           (state_reg == LS_WR)     ? wdata_sh[7:0] : 8'h00;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (grant_ls) begin
          cnt_next   = CW'(1);
          state_next = !bus.ls_we_i ? LS_RD : (ls_n == CW'(1)) ? DONE : LS_WR;
        end else if (grant_if) begin
          cnt_next   = CW'(1);
          state_next = IF_RD;
        end
      end
      LS_RD, IF_RD: begin
        // Flush aborts a fetch even while stalled so the abort is never lost.
        if (state_reg == IF_RD && bus.if_flush_i) begin
          state_next = IDLE;
        end else if (rdy_in) begin
          if (cnt_reg == n_reg) state_next = DONE;
          else                  cnt_next   = cnt_reg + CW'(1);
        end
      end
      LS_WR: begin
        if (rdy_in) begin
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == n_reg - CW'(1)) state_next = DONE;
        end
      end
      DONE: begin
        if (rdy_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      n_reg        <= CW'(1);
      base_reg     <= '0;
      is_if_reg    <= 1'b0;
      we_reg       <= 1'b0;
      wdata_reg    <= '0;
      ld_buf_reg   <= '0;
      line_buf_reg <= '0;
      if_data_reg  <= '0;
      ls_rdata_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ld_buf_reg   <= ld_next;
      line_buf_reg <= line_next;
      if (grant_ls) begin
        base_reg  <= bus.ls_addr_i;
        n_reg     <= ls_n;
        is_if_reg <= 1'b0;
        we_reg    <= bus.ls_we_i;
        wdata_reg <= bus.ls_wdata_i;
      end else if (grant_if) begin
        base_reg  <= bus.if_addr_i;
        n_reg     <= CW'(NB);
        is_if_reg <= 1'b1;
        we_reg    <= 1'b0;
      end
      if (if_done_w)            if_data_reg  <= line_buf_reg;
      if (ls_done_w && !we_reg) ls_rdata_reg <= ld_buf_reg & ld_mask;
    end
  end
endmodule

// File: doc/mem_ctrl_burst.md
# mem_ctrl_burst

Byte-serial RAM controller arbitrating between the instruction fetcher (multi-word line fills for the icache) and the LSU (1/2/4-byte loads and stores) over the single 8-bit RAM port. It sits between the fetcher/icache, the LSU and the RAM. It adds parametrised line bursts, per-request access size, fetch abort on flush, rdy_in stall handling and optional round-robin arbitration.

## Interface
- ADDR_W, 32, byte-address width for all address ports.
- LINE_WORDS, 4, 32-bit words per fetch burst (≥1); burst = 4*LINE_WORDS bytes.
- clk_in  input  1  clock, all state on rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global ready; low = stall.
- ram_wr_o  output  1  1 = write byte, 0 = read.
- ram_addr_o  output  ADDR_W  RAM byte address.
- ram_wdata_o  output  8  write byte.
- ram_rdata_i  input  8  read byte, valid one cycle after its address.
- if_req_i  input  1  fetch request, held until if_done_o or flush.
- if_addr_i  input  ADDR_W  line base address, stable while if_req_i.
- if_flush_i  input  1  abort outstanding/pending fetch.
- if_done_o  output  1  one-cycle pulse, line valid.
- if_data_o  output  32*LINE_WORDS  line; byte k at bits [8k+7:8k].
- ls_req_i  input  1  LSU request, held until ls_done_o.
- ls_we_i  input  1  1 = store, 0 = load.
- ls_size_i  input  2  0 = 1 byte, 1 = 2 bytes, 2/3 = 4 bytes.
- ls_addr_i  input  ADDR_W  start byte address (misalignment allowed).
- ls_wdata_i  input  32  store data, byte k = bits [8k+7:8k].
- ls_done_o  output  1  one-cycle pulse, load data valid / store complete.
- ls_rdata_o  output  32  load data, zero-extended above size.

## Operation
- States: IDLE, LS_RD, LS_WR, IF_RD, DONE.
- IDLE: no RAM access (ram_wr_o=0). If a request is pending, grant it this cycle (grant cycle = cycle 0) and drive byte 0 address in the same cycle.
- Byte k address = base + k, modulo 2^ADDR_W (wraps at top of space).
- Read (LS_RD/IF_RD): byte k address driven in cycle k; ram_rdata_i captured at end of cycle k+1 into byte k of the target register.
- Write (LS_WR): cycle k drives ram_wr_o=1, address base+k, ram_wdata_o = byte k of ls_wdata_i.
- N = bytes of access (1/2/4 for LSU, 4*LINE_WORDS for fetch).
- DONE: one cycle; pulse the matching done output; return to IDLE. Requests sampled in DONE are ignored; requester must drop req on seeing done.
- ls_rdata_o bytes beyond size are 0; sign extension is the LSU's job. Outputs hold last value until next completion of the same client.
- if_flush_i: while in IF_RD, next state IDLE, no if_done_o; flush in same cycle a fetch would be granted blocks the grant; flush coincident with DONE of a fetch suppresses if_done_o. Flush never affects LSU transactions.
- Reset mid-operation: immediate return to IDLE, all outputs to reset values, transaction discarded.

## Timing
- Reset values: ram_wr_o=0, ram_addr_o=0, ram_wdata_o=0, if_done_o=0, if_data_o=0, ls_done_o=0, ls_rdata_o=0, arbitration pointer = fetch-last.
- Load N bytes: done in cycle N+1 after grant; store N bytes: done in cycle N; fetch: done in cycle 4*LINE_WORDS+1.
- Back-to-back: next grant earliest in cycle after DONE.
- rdy_in low: all state frozen, ram_addr_o held, ram_wr_o forced 0; pending read capture deferred until a cycle with rdy_in high (address still held, so data stays valid); interrupted write byte re-driven on resume. Done pulses never issued while rdy_in low.

## Configuration
- MEMCTRL_RR_ARB_EN defined: round-robin; on simultaneous requests in IDLE, grant the client not granted last; pointer starts fetch-last, so LSU wins the first tie.
- Undefined: fixed priority, LSU always wins ties; fetch may starve under continuous LSU traffic.

## Test plan
- 4-byte load from 0x100 holding 0x11,0x22,0x33,0x44 -> ram_addr_o 0x100..0x103 cycles 0-3, ls_done_o in cycle 5, ls_rdata_o=0x44332211.
- 2-byte store 0xBEEF at 0x1FF -> writes 0xEF@0x1FF, 0xBE@0x200 in cycles 0-1, ls_done_o cycle 2, no write in cycle 2.
- LINE_WORDS=4 fetch at 0x0 -> 16 sequential reads, if_done_o cycle 17, if_data_o[31:0] = word at 0x0; flush asserted at cycle 6 -> no if_done_o, IDLE at cycle 7, next request granted cleanly.
- ls_req_i and if_req_i rising together three times in a row -> without macro: LSU,LSU,LSU grants; with MEMCTRL_RR_ARB_EN: LSU,fetch,LSU.
- rdy_in low for 3 cycles during byte 2 of a 4-byte store -> ram_wr_o=0 during stall, byte 2 re-driven once on resume, ls_done_o delayed by exactly 3 cycles, RAM contents correct.
- rst_n_in pulsed low mid-fetch -> all outputs zero asynchronously, no done pulse, controller grants a fresh request in the first cycle after release.
